// File: rtl/cdp1802_io_bank.sv
// CDP1802-style I/O bank: N-line decoded output latches with write strobes,
// per-port input FIFOs read through the INP path, sticky underrun flags,
// a status port at N=7 and EF flag lines summarising FIFO state.
// The status word places the underrun summary at bit 7, so W must be >= 8.
module cdp1802_io_bank #(
  parameter int NPORTS = 4,
  parameter int W      = 8,
  parameter int DEPTH  = 4
) (
  input  logic                clock,
  input  logic                resetq,
  input  logic [2:0]          io_n,
  input  logic                io_wr,
  input  logic                io_rd,
  input  logic [W-1:0]        io_wdata,
  output logic [W-1:0]        io_rdata,
  output logic [3:0]          ef,
  output logic [NPORTS*W-1:0] out_data,
  output logic [NPORTS-1:0]   out_stb,
  input  logic [NPORTS*W-1:0] in_data,
  input  logic [NPORTS-1:0]   in_valid,
  output logic [NPORTS-1:0]   in_ready
);
  localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW        = AW + 1;
  localparam logic [2:0]    STAT_PORT = 3'd7;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [W-1:0]      r_out [NPORTS];
  logic [NPORTS-1:0] r_stb;
  logic [W-1:0]      r_mem [NPORTS][DEPTH];
  logic [AW-1:0]     r_wp  [NPORTS];
  logic [AW-1:0]     r_rp  [NPORTS];
  logic [CW-1:0]     r_cnt [NPORTS];
  logic [NPORTS-1:0] r_unf;

  logic [NPORTS-1:0] w_sel;
  logic [NPORTS-1:0] w_wr;
  logic [NPORTS-1:0] w_push;
  logic [NPORTS-1:0] w_pop;
  logic [NPORTS-1:0] w_uset;
  logic [NPORTS-1:0] w_uclr;
  logic [NPORTS-1:0] w_nonempty;
  logic [NPORTS-1:0] w_full;
  logic              w_stat_sel;
  logic [7:0]        w_status;
  logic [W-1:0]      w_head;

  // Decode the N lines and derive per-port push/pop/underrun events
  always_comb begin
    w_stat_sel = (io_n == STAT_PORT);
    for (int k = 0; k < NPORTS; k++) begin
      w_sel[k]      = (io_n == 3'(k + 1));
      w_nonempty[k] = (r_cnt[k] != '0);
      w_full[k]     = (r_cnt[k] == FULL_CNT);
      w_wr[k]       = w_sel[k] & io_wr;
      w_pop[k]      = w_sel[k] & io_rd & w_nonempty[k];
      w_uset[k]     = w_sel[k] & io_rd & ~w_nonempty[k];
      w_uclr[k]     = w_stat_sel & io_wr & io_wdata[k];
      // Readiness comes from the registered count only; a same-cycle pop
      // does not make room for a push into a full FIFO.
      w_push[k]     = in_valid[k] & ~w_full[k];
    end
  end

  // INP data path: FIFO head, status word, or all ones when nothing to give
  always_comb begin
    w_status             = '0;
    w_status[NPORTS-1:0] = w_nonempty;
    w_status[7]          = |r_unf;
    w_head               = '1;
    for (int k = 0; k < NPORTS; k++) begin
      if (w_sel[k] && w_nonempty[k]) begin
        w_head = r_mem[k][r_rp[k]];
      end
    end
    io_rdata = w_stat_sel ? W'(w_status) : w_head;
  end

  // Pack latches onto the output bus and summarise FIFO state on the EF lines
  always_comb begin
    for (int k = 0; k < NPORTS; k++) begin
      out_data[k*W +: W] = r_out[k];
      in_ready[k]        = resetq & ~w_full[k];
    end
    out_stb = r_stb;
    ef      = {1'b0, |r_unf, |w_full, |w_nonempty};
  end

  // Output latches and their one-cycle write strobes
  always_ff @(posedge clock or negedge resetq) begin
    if (!resetq) begin
      for (int k = 0; k < NPORTS; k++) begin
        r_out[k] <= '0;
      end
      r_stb <= '0;
    end else begin
      r_stb <= w_wr;
      for (int k = 0; k < NPORTS; k++) begin
        if (w_wr[k]) begin
          r_out[k] <= io_wdata;
        end
      end
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count alone
  always_ff @(posedge clock or negedge resetq) begin
    if (!resetq) begin
      for (int k = 0; k < NPORTS; k++) begin
        r_wp[k]  <= '0;
        r_rp[k]  <= '0;
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NPORTS; k++) begin
        if (w_push[k]) begin
          r_wp[k] <= r_wp[k] + AW'(1);
        end
        if (w_pop[k]) begin
          r_rp[k] <= r_rp[k] + AW'(1);
        end
        case ({w_push[k], w_pop[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + CW'(1);
          2'b01:   r_cnt[k] <= r_cnt[k] - CW'(1);
          default: r_cnt[k] <= r_cnt[k];
        endcase
      end
    end
  end

  // FIFO storage; entries are meaningful only between the pointers
  always_ff @(posedge clock) begin
    for (int k = 0; k < NPORTS; k++) begin
      if (w_push[k]) begin
        r_mem[k][r_wp[k]] <= in_data[k*W +: W];
      end
    end
  end

  // Sticky underrun bits; a new underrun beats a same-cycle clear
  always_ff @(posedge clock or negedge resetq) begin
    if (!resetq) begin
      r_unf <= '0;
    end else begin
      r_unf <= (r_unf & ~w_uclr) | w_uset;
    end
  end

endmodule
